// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flip-flop,
// processing A+B or A-B LSB first over WIDTH clocks with a start/busy/done handshake.
module serial_addsub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ofl,
  output logic             Zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_b_q;
  logic [WIDTH-2:0] res_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q;
  logic [WIDTH-1:0] s_q;
  logic             cout_q, ofl_q, zero_q;

  logic             sum_bit, c_next, last_bit, load;
  logic [WIDTH-1:0] res_shift;

  // The single full-adder cell.
  assign sum_bit   = op_a_q[0] ^ op_b_q[0] ^ c_q;
  assign c_next    = (op_a_q[0] & op_b_q[0]) | (op_a_q[0] & c_q) | (op_b_q[0] & c_q);
  assign last_bit  = (cnt_q == CW'(WIDTH - 1));
  // Result register holds WIDTH-1 bits; the final bit joins it only at completion.
  assign res_shift = {sum_bit, res_q};
  // A new request is accepted in IDLE and also in DONE for back-to-back operation.
  assign load      = start && (state_q != RUN);

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the reset is synchronous,
  // so it lives inside the clocked branch rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ofl_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        // Subtraction is A + ~B + 1: invert B and preset the carry.
        op_a_q <= A;
        op_b_q <= sub ? ~B : B;
        c_q    <= sub;
        cnt_q  <= '0;
        res_q  <= '0;
      end else if (state_q == RUN) begin
        op_a_q <= op_a_q >> 1;
        op_b_q <= op_b_q >> 1;
        c_q    <= c_next;
        cnt_q  <= cnt_q + 1'b1;
        res_q  <= res_shift[WIDTH-1:1];
        if (last_bit) begin
          // c_q here is the carry into the MSB; overflow when it differs from carry out.
          s_q    <= res_shift;
          cout_q <= c_next;
          ofl_q  <= c_q ^ c_next;
          zero_q <= (res_shift == '0);
        end
      end
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign S    = s_q;
  assign Cout = cout_q;
  assign Ofl  = ofl_q;
  assign Zero = zero_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: directed operations push expected results,
// a negedge monitor pops and compares on every done pulse and checks busy length.
module tb_serial_addsub;

  localparam int WIDTH = 16;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ofl;
    logic             zero;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] A, B;
  logic             busy, done;
  logic [WIDTH-1:0] S;
  logic             Cout, Ofl, Zero;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   busy_run = 0;

  serial_addsub #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .sub  (sub),
    .A    (A),
    .B    (B),
    .busy (busy),
    .done (done),
    .S    (S),
    .Cout (Cout),
    .Ofl  (Ofl),
    .Zero (Zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares outputs on each done pulse and the busy length preceding it.
  always @(negedge clk) begin
    if (done) begin
      check("busy_cycles", busy_run, WIDTH);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("S", S, e.s);
        check("Cout", Cout, e.cout);
        check("Ofl", Ofl, e.ofl);
        check("Zero", Zero, e.zero);
      end
      busy_run = 0;
    end else if (busy) begin
      busy_run++;
    end else begin
      busy_run = 0;
    end
  end

  task automatic push(input logic [WIDTH-1:0] s, input logic c, input logic o, input logic z);
    exp_t e;
    e.s = s; e.cout = c; e.ofl = o; e.zero = z;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check({name, "_timeout"}, exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic op(input logic m, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                    input logic [WIDTH-1:0] s, input logic c, input logic o, input logic z);
    @(negedge clk);
    start = 1'b1; sub = m; A = a; B = b;
    push(s, c, o, z);
    @(negedge clk);
    start = 1'b0;
    drain("op", 3 * WIDTH);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_S", S, 0);
    check("rst_flags", {Cout, Ofl, Zero}, 0);
    rst_n = 1'b1;

    op(1'b1, 16'h0005, 16'h0003, 16'h0002, 1'b1, 1'b0, 1'b0);
    op(1'b1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    op(1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    op(1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
    op(1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);
    op(1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1);
    op(1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0);

    // Handshake: start held high; A changes mid-run and is picked up only by the second op.
    @(negedge clk);
    start = 1'b1; sub = 1'b1; A = 16'h0010; B = 16'h0001;
    push(16'h000F, 1'b1, 1'b0, 1'b0);
    push(16'hFFFE, 1'b1, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    A = 16'hFFFF;
    begin
      int n;
      n = 0;
      while (!done && n < 3 * WIDTH) begin
        @(negedge clk);
        n++;
      end
      check("hs_first_done_seen", done, 1);
    end
    @(negedge clk);
    start = 1'b0;
    check("hs_back_to_back_busy", busy, 1);
    repeat (4) @(negedge clk);
    start = 1'b1; sub = 1'b0; A = 16'h0000; B = 16'h0000;
    @(negedge clk);
    start = 1'b0;
    drain("handshake", 3 * WIDTH);
    repeat (WIDTH + 4) @(negedge clk);
    check("hs_idle_busy", busy, 0);
    check("hs_hold_S", S, 16'hFFFE);

    // Reset mid-operation: no done may follow, outputs return to reset values.
    @(negedge clk);
    start = 1'b1; sub = 1'b1; A = 16'h0005; B = 16'h0003;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("hold_S_during_run", S, 16'hFFFE);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", busy, 0);
    check("abort_S", S, 0);
    check("abort_flags", {Cout, Ofl, Zero}, 0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (done) seen++;
      end
      check("abort_no_done", seen, 0);
    end

    op(1'b1, 16'h0005, 16'h0003, 16'h0002, 1'b1, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Bit-serial adder/subtractor: computes A+B or A−B one bit per clock, LSB first.
- Uses a single full-adder cell and a registered carry/borrow flip-flop.
- Counterpart to the combinational ripple adders: the subtract direction, time-multiplexed onto one adder bit.
- Sits beside the ALU as a low-area arithmetic unit, driven by a start/busy/done handshake.

Parameters:
WIDTH  16  operand and result width in bits; legal range 2..32

Ports:
clk    input   1      system clock; all state changes on rising edge
rst_n  input   1      synchronous reset, active low; sampled on rising edge of clk
start  input   1      request; sampled only when busy=0
sub    input   1      mode, sampled with start; 1 = A−B, 0 = A+B
A      input   WIDTH  operand A, sampled with start
B      input   WIDTH  operand B, sampled with start
busy   output  1      high while an operation is in progress
done   output  1      one-cycle pulse; S/Cout/Ofl/Zero valid from this cycle on
S      output  WIDTH  result
Cout   output  1      final carry out; for sub, 1 = no borrow (A >= B unsigned)
Ofl    output  1      two's-complement signed overflow
Zero   output  1      1 when S == 0

Behaviour:
- Reset: rst_n=0 at a rising edge gives
  - state IDLE; busy=0, done=0;
  - S=0, Cout=0, Ofl=0, Zero=0;
  - operand shift registers, carry FF and bit counter all cleared.
- Reset wins over every other input in the same cycle.
- State machine: IDLE, RUN, DONE.
- IDLE -> RUN: on an edge with start=1.
  - Load opA=A.
  - Load opB = sub ? ~B : B.
  - Load carry FF = sub.
  - Clear counter and result register.
  - Latch sub.
- RUN, each edge:
  - s = opA[0]^opB[0]^c.
  - c_next = majority(opA[0], opB[0], c).
  - s is shifted into the result MSB (result shifts right).
  - opA and opB shift right.
  - Counter increments.
  - Record c (carry into the current bit) when counter == WIDTH−1, for overflow.
- RUN -> DONE: on the edge that processes bit WIDTH−1 (counter == WIDTH−1).
  - That edge also registers the outputs:
    - S = completed result;
    - Cout = c_next;
    - Ofl = c_in_msb XOR c_next;
    - Zero = (S == 0).
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - Next edge: goes to RUN if start=1 (back-to-back accepted), else IDLE.
- Latency and busy:
  - With start sampled at edge t, busy is high from after edge t until after edge t+WIDTH.
  - done is high during the cycle following edge t+WIDTH.
  - Total: WIDTH cycles start-to-done.
- Output hold: S, Cout, Ofl, Zero are updated only at the RUN->DONE edge. They hold through the following IDLE and any subsequent RUN until the next completion.
- start=1 while busy=1 is ignored. A, B and sub changes during RUN have no effect.
- Reset mid-operation: the operation is aborted, no done pulse is produced, and all outputs take their reset values.
- Widths: no output is wider than WIDTH+1 bits total. Wrap-around is modulo 2^WIDTH; overflow is reported only via Cout/Ofl.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Subtract, no borrow: sub=1, A=0x0005, B=0x0003, start pulse.
  -> busy 16 cycles; done pulse 16 cycles after start is sampled.
  -> S=0x0002, Cout=1, Ofl=0, Zero=0.
- Subtract with borrow: sub=1, A=0x0003, B=0x0005.
  -> S=0xFFFE, Cout=0, Ofl=0, Zero=0.
- Signed overflow:
  - sub=1, A=0x8000, B=0x0001 -> S=0x7FFF, Cout=1, Ofl=1.
  - Then sub=0, A=0x7FFF, B=0x0001 -> S=0x8000, Cout=0, Ofl=1.
- Wrap to zero:
  - sub=0, A=0xFFFF, B=0x0001 -> S=0x0000, Cout=1, Zero=1.
  - sub=1, A=B=0x1234 -> S=0x0000, Cout=1, Zero=1, Ofl=0.
- Handshake:
  - start held high continuously with A=0x0010, B=0x0001, sub=1.
  - Changing A to 0xFFFF mid-RUN must not affect the result.
  -> First done gives S=0x000F; the next operation starts in the done cycle and completes exactly 16 cycles later.
  - A start pulse mid-RUN is ignored.
- Reset mid-operation: start sub=1, A=0x0005, B=0x0003; drive rst_n=0 for one edge 7 cycles later.
  -> busy=0, S=0, Cout=0, Ofl=0, Zero=0; no done pulse for 20 cycles.
  - A new start then completes normally.
